psum_row_accum: RTL and testbench
=================================

PSUM_ROW_ACCUM -- requirements
Module: psum_row_accum

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 3: PE psums summed per output pixel; legal range 2..16.
REQ-002 SHALL have parameter PSUM_WIDTH, default 32: width of the PE psum input.
REQ-003 SHALL have parameter FRAC_BITS, default 8: fraction bits removed at requantization.
REQ-004 SHALL have parameter OUT_WIDTH, default 16: signed result width.
REQ-005 SHALL use clock clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 SHALL use reset rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have clear, input, 1 bit: synchronous abort of the accumulation in flight.
REQ-008 SHALL have pe_done, input, 1 bit: PE done level; a rising edge marks a valid psum.
REQ-009 SHALL have pe_psum, input, PSUM_WIDTH, signed: PE output psum.
REQ-010 SHALL have in_ready, output, 1 bit: high when a completing row can be stored.
REQ-011 SHALL have row_idx, output, clog2(NUM_ROWS) bits: number of psums accumulated so far.
REQ-012 SHALL have out_valid, output, 1 bit: a result is available.
REQ-013 SHALL have out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have out_data, output, OUT_WIDTH, signed: requantized result.
REQ-015 SHALL have overflow, output, 1 bit: sticky flag set when a result is dropped.

Function
REQ-016 SHALL register pe_done into pe_done_q; psum event = pe_done AND NOT pe_done_q, sampled at the same edge.
REQ-017 SHALL hold an accumulator of PSUM_WIDTH+clog2(NUM_ROWS) bits with sign extension.
- No intermediate overflow is permitted.
REQ-018 On an event with row_idx < NUM_ROWS-1, SHALL set acc <= acc + pe_psum and increment row_idx.
REQ-019 On an event with row_idx == NUM_ROWS-1, SHALL:
- form the final sum acc + pe_psum;
- requantize it and push it into the output FIFO;
- zero acc and wrap row_idx to 0;
- all in the same edge.
REQ-020 SHALL requantize as follows:
- add 2^(FRAC_BITS-1);
- arithmetic-shift right by FRAC_BITS, giving round-half-up;
- saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-021 SHALL buffer results in a 2-entry FIFO; out_data = head entry; out_valid = FIFO non-empty.
- Latency: out_valid rises the cycle after the final-row edge.
REQ-022 SHALL pop the FIFO on each edge where out_valid AND out_ready are high.
- out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive in_ready = NOT full OR out_ready.
- Push and pop in the same cycle on a full FIFO SHALL succeed and keep the count at 2.
REQ-024 Final-row event when in_ready=0 SHALL:
- drop the result;
- set overflow=1;
- still zero acc and wrap row_idx.
REQ-025 Non-final-row events SHALL be accepted regardless of in_ready.
REQ-026 clear SHALL zero acc, row_idx, the FIFO count and overflow, and SHALL override a simultaneous event or pop.
REQ-027 pe_done held high for many cycles SHALL produce exactly one event.

Reset
REQ-028 SHALL on rst zero the following asynchronously: acc, row_idx, pe_done_q, the FIFO pointers/count, overflow and out_data.
- Consequently out_valid=0 and in_ready=1 during and after reset.
REQ-029 rst mid-accumulation SHALL discard partial sums.
- pe_done already high on release SHALL count as one event at the first edge.

Configuration
REQ-030 With PSUM_ROW_ACCUM_RELU_EN defined, SHALL clamp negative final sums to 0 before rounding and saturation.
REQ-031 Without PSUM_ROW_ACCUM_RELU_EN, SHALL pass signed results unchanged into rounding and saturation.

Verification
REQ-032 Basic sum:
- Stimulus: psums 256, 512, 768 via three pe_done rising edges, out_ready=1.
- Response: out_data=6, out_valid high exactly 1 cycle after the third edge.
REQ-033 Rounding and sign:
- psums 128, 128, 128 (sum 384) -> out_data=2.
- psums -1280, 0, 0 -> out_data=-5 without RELU_EN; out_data=0 with RELU_EN.
REQ-034 Saturation:
- psums 0x01000000 x3 -> out_data=32767.
- psums -0x01000000 x3 (no RELU_EN) -> out_data=-32768.
REQ-035 Backpressure:
- Stimulus: out_ready=0, three full pixels.
- Response: first two results held in order; in_ready=0 after the second; third dropped; overflow=1.
- Then out_ready=1 -> the two results drain in order.
REQ-036 Level and clear:
- pe_done held high 10 cycles -> row_idx advances by 1 only.
- clear asserted after 2 rows -> row_idx=0 and the next 3 rows produce a correct fresh sum.
- rst asserted mid-pixel -> same result as clear.

Source files
------------

// File: rtl/psum_row_accum.sv
// Sums NUM_ROWS PE partial sums per output pixel, requantizes with round-half-up and
// saturation, and queues results in a 2-entry FIFO. Define PSUM_ROW_ACCUM_RELU_EN to clamp negative sums.
module psum_row_accum #(
  parameter int NUM_ROWS   = 3,
  parameter int PSUM_WIDTH = 32,
  parameter int FRAC_BITS  = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         pe_done,
  input  logic signed [PSUM_WIDTH-1:0] pe_psum,
  output logic                         in_ready,
  output logic [$clog2(NUM_ROWS)-1:0]  row_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         overflow
);
  localparam int IDX_W = $clog2(NUM_ROWS);
  localparam int ACC_W = PSUM_WIDTH + IDX_W;
  localparam int RND_W = ACC_W + 1;
  localparam logic signed [RND_W-1:0] SAT_MAX = {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN = {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic                        pe_done_q;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]            row_idx_q, row_idx_d;
  logic [1:0]                  count_q, count_d;
  logic                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                        overflow_q, overflow_d;
  logic signed [OUT_WIDTH-1:0] mem_q [2];

  logic                        psum_event, is_final, push, pop;
  logic signed [ACC_W-1:0]     psum_ext, final_sum, relu_sum;
  logic signed [RND_W-1:0]     rnd_sum, shifted;
  logic signed [OUT_WIDTH-1:0] quant;

  assign psum_event = pe_done & ~pe_done_q;
  assign is_final   = (row_idx_q == IDX_W'(NUM_ROWS - 1));
  assign out_valid  = (count_q != 2'd0);
  assign in_ready   = (count_q != 2'd2) | out_ready;
  assign push       = psum_event & is_final & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_data   = mem_q[rd_ptr_q];
  assign row_idx    = row_idx_q;
  assign overflow   = overflow_q;

  // Accumulator carries IDX_W guard bits so NUM_ROWS psums can never wrap.
  assign psum_ext  = {{IDX_W{pe_psum[PSUM_WIDTH-1]}}, pe_psum};
  assign final_sum = acc_q + psum_ext;
`ifdef PSUM_ROW_ACCUM_RELU_EN
  assign relu_sum  = final_sum[ACC_W-1] ? '0 : final_sum;
`else
  assign relu_sum  = final_sum;
`endif
  assign rnd_sum   = {relu_sum[ACC_W-1], relu_sum} + (RND_W'(1) << (FRAC_BITS - 1));
  assign shifted   = rnd_sum >>> FRAC_BITS;

  always_comb begin
    quant = shifted[OUT_WIDTH-1:0];
    if (shifted > SAT_MAX)      quant = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) quant = SAT_MIN[OUT_WIDTH-1:0];
  end

  always_comb begin
    acc_d      = acc_q;
    row_idx_d  = row_idx_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear) begin
      acc_d      = '0;
      row_idx_d  = '0;
      count_d    = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (psum_event) begin
        if (is_final) begin
          acc_d     = '0;
          row_idx_d = '0;
          if (!in_ready) overflow_d = 1'b1;
        end else begin
          acc_d     = final_sum;
          row_idx_d = row_idx_q + IDX_W'(1);
        end
      end
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_done_q  <= 1'b0;
      acc_q      <= '0;
      row_idx_q  <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      overflow_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      pe_done_q  <= pe_done;
      acc_q      <= acc_d;
      row_idx_q  <= row_idx_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      // A push onto a full FIFO only happens alongside a pop, so the slot it overwrites is the departing head.
      if (push && !clear) mem_q[wr_ptr_q] <= quant;
    end
  end
endmodule

// File: tb/tb_psum_row_accum.sv
// Scoreboard bench for psum_row_accum: expected pixels are queued when the final row is
// driven and compared as the FIFO pops; status outputs are checked directly.
module tb_psum_row_accum;
  localparam int NUM_ROWS   = 3;
  localparam int PSUM_WIDTH = 32;
  localparam int FRAC_BITS  = 8;
  localparam int OUT_WIDTH  = 16;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         clear;
  logic                         pe_done;
  logic signed [PSUM_WIDTH-1:0] pe_psum;
  logic                         in_ready;
  logic [$clog2(NUM_ROWS)-1:0]  row_idx;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         overflow;

  int     checks   = 0;
  int     failures = 0;
  longint exp_q[$];

  psum_row_accum #(
    .NUM_ROWS(NUM_ROWS), .PSUM_WIDTH(PSUM_WIDTH), .FRAC_BITS(FRAC_BITS), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .pe_done(pe_done), .pe_psum(pe_psum),
    .in_ready(in_ready), .row_idx(row_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic longint model(input longint sum);
    longint s, r;
    s = sum;
`ifdef PSUM_ROW_ACCUM_RELU_EN
    if (s < 0) s = 0;
`endif
    r = (s + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
    if (r > (longint'(1) << (OUT_WIDTH - 1)) - 1) r = (longint'(1) << (OUT_WIDTH - 1)) - 1;
    if (r < -(longint'(1) << (OUT_WIDTH - 1)))    r = -(longint'(1) << (OUT_WIDTH - 1));
    return r;
  endfunction

  // One pe_done rising edge; returns 1 time unit after the edge that samples it.
  task automatic pulse(input longint v);
    @(posedge clk); #1;
    pe_done = 1'b1;
    pe_psum = v[PSUM_WIDTH-1:0];
    @(posedge clk); #1;
    pe_done = 1'b0;
  endtask

  task automatic send_pixel(input longint a, input longint b, input longint c, input bit expect_push);
    pulse(a);
    pulse(b);
    pulse(c);
    if (expect_push) exp_q.push_back(model(a + b + c));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", exp_q.size(), 1);
      else check("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint a, b, c;
    rst = 1'b1; clear = 1'b0; pe_done = 1'b0; pe_psum = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_row_idx", row_idx, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic sum and one-cycle latency
    pulse(256); pulse(512);
    check("basic_row_idx", row_idx, 2);
    check("basic_valid_before", out_valid, 0);
    pulse(768);
    exp_q.push_back(6);
    check("basic_valid_after", out_valid, 1);
    check("basic_data", out_data, 6);
    drain("basic_drain");

    // Rounding, sign and saturation
    send_pixel(128, 128, 128, 1);
    send_pixel(-1280, 0, 0, 1);
    send_pixel(64'h0100_0000, 64'h0100_0000, 64'h0100_0000, 1);
    send_pixel(-64'sh0100_0000, -64'sh0100_0000, -64'sh0100_0000, 1);
    drain("round_sat_drain");

    for (int i = 0; i < 4; i++) begin
      a = longint'($urandom_range(0, 2097152)) - 1048576;
      b = longint'($urandom_range(0, 2097152)) - 1048576;
      c = longint'($urandom_range(0, 2097152)) - 1048576;
      send_pixel(a, b, c, 1);
    end
    drain("random_drain");

    // Backpressure: two held, third dropped
    out_ready = 1'b0;
    send_pixel(512, 512, 512, 1);
    check("bp_in_ready_1", in_ready, 1);
    send_pixel(1024, 0, 1024, 1);
    check("bp_in_ready_2", in_ready, 0);
    check("bp_overflow_pre", overflow, 0);
    send_pixel(2560, 0, 0, 0);
    check("bp_overflow", overflow, 1);
    check("bp_row_idx", row_idx, 0);
    check("bp_head", out_data, exp_q[0]);
    @(posedge clk); #1;
    check("bp_head_stable", out_data, exp_q[0]);
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_overflow_sticky", overflow, 1);
    clear = 1'b1; @(posedge clk); #1 clear = 1'b0;
    check("clear_overflow", overflow, 0);

    // Push and pop on a full FIFO in the same edge
    out_ready = 1'b0;
    send_pixel(300, 300, 300, 1);
    send_pixel(-700, 100, 0, 1);
    pulse(1000); pulse(1000);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    pe_done = 1'b1; pe_psum = 1000; out_ready = 1'b1;
    exp_q.push_back(model(3000));
    @(posedge clk); #1;
    pe_done = 1'b0;
    check("full_pushpop_overflow", overflow, 0);
    check("full_pushpop_valid", out_valid, 1);
    drain("full_drain");

    // Level-held pe_done counts once
    @(posedge clk); #1;
    pe_done = 1'b1; pe_psum = 100;
    repeat (10) @(posedge clk);
    #1;
    check("level_row_idx", row_idx, 1);
    pe_done = 1'b0;
    pulse(200);
    check("pre_clear_row_idx", row_idx, 2);
    clear = 1'b1; @(posedge clk); #1 clear = 1'b0;
    check("clear_row_idx", row_idx, 0);
    send_pixel(256, 256, 256, 1);
    drain("clear_fresh_drain");

    // Reset mid-pixel, pe_done high on release
    pulse(5000); pulse(5000);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midrst_row_idx", row_idx, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    pe_done = 1'b1; pe_psum = 1024;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("release_event_row_idx", row_idx, 1);
    pe_done = 1'b0;
    pulse(1024);
    pulse(1024);
    exp_q.push_back(model(3072));
    drain("rst_fresh_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
